pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and control-flow scheduler for the 4-stage CPU pipeline (IF, ID, EX, WB; buffers IF/ID, ID/EX, EX/WB).
- Tracks in-flight register writes in a scoreboard and stalls the ID stage on read-after-write hazards.
- Holds fetch while a branch or jump is unresolved, and flushes IF/ID when the WB stage redirects the PC.
- Drives the PC and IF/ID write enables, the ID/EX bubble and the IF/ID flush. It also keeps a stall-cycle counter.

Parameters:
- NREG, 64, number of architectural registers (register index width 6).
- CTRL_TIMEOUT, 4, maximum cycles in CTRL_WAIT before the error flag is raised.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_id_valid  in  1  ID stage holds a real instruction.
- in_id_rs  in  6  source register rs of the ID instruction (inst[21:16]).
- in_id_rt  in  6  source register rt of the ID instruction (inst[15:10]).
- in_id_uses_rs  in  1  the ID instruction reads rs.
- in_id_uses_rt  in  1  the ID instruction reads rt.
- in_id_rd  in  6  destination register of the ID instruction (inst[27:22]).
- in_id_ctrl_regwrt  in  1  the ID instruction writes rd.
- in_id_ctrl_flow  in  1  the ID instruction is a branch or jump.
- in_wb_ctrl_regwrt  in  1  the WB-stage instruction writes a register this cycle.
- in_wb_rd  in  6  destination register of the WB-stage instruction.
- in_wb_ctrl_flow  in  1  the WB-stage instruction is a branch or jump, so it resolves this cycle.
- in_wb_redirect  in  1  PC-control select output; 1 means the PC takes the target.
- out_pc_write  out  1  PC load enable.
- out_ifid_write  out  1  IF/ID load enable.
- out_ifid_flush  out  1  IF/ID is cleared to a NOP on the next edge.
- out_idex_bubble  out  1  ID/EX loads zero control signals on the next edge.
- out_stall_count  out  CNT_W  saturating count of cycles with out_idex_bubble=1.
- out_err  out  1  sticky flag for a control-resolution timeout or scoreboard underflow/overflow.

Behaviour:
Reset (asynchronous, immediate):
- All scoreboard counters are 0, state is RUN, timeout counter is 0.
- out_stall_count=0 and out_err=0.
- Combinational outputs in RUN with no hazard: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.

Scoreboard:
- One 2-bit pending counter per register.
- Issue: in_id_valid & in_id_ctrl_regwrt & ~out_idex_bubble increments pend[in_id_rd].
- Commit: in_wb_ctrl_regwrt decrements pend[in_wb_rd].
- Issue and commit on the same register in the same cycle leave the counter unchanged.
- Increment at 3 saturates and sets out_err; decrement at 0 stays 0 and sets out_err.

RAW hazard, combinational:
- raw = in_id_valid & ((in_id_uses_rs & pend[rs]!=0) | (in_id_uses_rt & pend[rt]!=0)).
- The check is made against the pre-update counter. A register committing in WB this cycle still counts as pending, because the write lands at the edge.

States:
- RUN:
  - If raw: pc_write=0, ifid_write=0, idex_bubble=1. State stays RUN.
  - Else if in_id_valid & in_id_ctrl_flow: the instruction issues and the state goes to CTRL_WAIT, with the timeout counter set to 0.
  - Else: normal flow.
- CTRL_WAIT:
  - pc_write=0, ifid_write=0, idex_bubble=1 every cycle. The wrong-path fetch is held in IF/ID.
  - Timeout counter increments each cycle.
  - On in_wb_ctrl_flow & in_wb_redirect: pc_write=1 (PC loads the target), ifid_flush=1, and the state goes to RUN.
  - On in_wb_ctrl_flow & ~in_wb_redirect: pc_write=0, no flush, and the state goes to RUN. The held IF/ID instruction is the correct fall-through and proceeds.
  - If the timeout counter reaches CTRL_TIMEOUT with no resolution: set out_err and go to RUN with no flush.
- Nominal control latency: issue at cycle t, resolution at t+2, giving 2 bubble cycles.

Priority and boundary rules:
- In RUN, raw is checked before the flow check, so a branch whose operands are pending stalls first.
- Redirect in WB while in RUN (no flow instruction in flight) is ignored and sets out_err.
- Bubbles never increment the scoreboard.
- out_stall_count increments on every cycle with idex_bubble=1 and saturates at all-ones. It does not wrap.
- Reset asserted mid-stall clears everything asynchronously. The next cycle after release is RUN with no hazard.

Test Plan:
1. Reset release, then 5 independent instructions (uses_rs=1, no pending writes) -> pc_write=1 and idex_bubble=0 every cycle; out_stall_count=0.
2. ID writes r5, next ID reads r5 (uses_rs) -> bubbles while pend[5]=1 (commit at WB two cycles after issue) -> stall_count=2; PC held for those 2 cycles.
3. Branch in ID, WB reports flow=1 and redirect=1 two cycles later -> 2 bubbles, then ifid_flush=1 and pc_write=1 in the resolution cycle; RUN next cycle.
4. Same as 3 with redirect=0 -> no flush; pc_write=0 in the resolution cycle, then the held IF/ID instruction issues the following cycle.
5. Issue r7 and commit r7 in the same cycle with pend[7]=1 -> pend[7] stays 1, so an ID read of r7 stalls. Decrement with pend=0 -> out_err=1.
6. Branch issued, no WB resolution for 4 cycles -> out_err=1 and return to RUN. rst pulse mid-CTRL_WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard/control scheduler.
// The datapath side is master; the scheduler is slave.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             in_id_valid;
   logic [5:0]       in_id_rs;
   logic [5:0]       in_id_rt;
   logic             in_id_uses_rs;
   logic             in_id_uses_rt;
   logic [5:0]       in_id_rd;
   logic             in_id_ctrl_regwrt;
   logic             in_id_ctrl_flow;
   logic             in_wb_ctrl_regwrt;
   logic [5:0]       in_wb_rd;
   logic             in_wb_ctrl_flow;
   logic             in_wb_redirect;
   logic             out_pc_write;
   logic             out_ifid_write;
   logic             out_ifid_flush;
   logic             out_idex_bubble;
   logic [CNT_W-1:0] out_stall_count;
   logic             out_err;

   modport master (
      output in_id_valid, in_id_rs, in_id_rt, in_id_uses_rs, in_id_uses_rt,
             in_id_rd, in_id_ctrl_regwrt, in_id_ctrl_flow,
             in_wb_ctrl_regwrt, in_wb_rd, in_wb_ctrl_flow, in_wb_redirect,
      input  out_pc_write, out_ifid_write, out_ifid_flush, out_idex_bubble,
             out_stall_count, out_err
   );

   modport slave (
      input  in_id_valid, in_id_rs, in_id_rt, in_id_uses_rs, in_id_uses_rt,
             in_id_rd, in_id_ctrl_regwrt, in_id_ctrl_flow,
             in_wb_ctrl_regwrt, in_wb_rd, in_wb_ctrl_flow, in_wb_redirect,
      output out_pc_write, out_ifid_write, out_ifid_flush, out_idex_bubble,
             out_stall_count, out_err
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// RAW-hazard scoreboard and branch/jump resolution scheduler for the 4-stage pipeline.
//   state        | meaning
//   ST_RUN       | normal issue; stalls ID on RAW hazards
//   ST_CTRL_WAIT | branch/jump in flight; fetch held until WB resolves it or it times out
module pipeline_hazard_ctrl #(
   parameter int NREG         = 64,
   parameter int CTRL_TIMEOUT = 4,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int TMO_W = $clog2(CTRL_TIMEOUT + 1);

   typedef enum logic {ST_RUN, ST_CTRL_WAIT} state_t;

   state_t           state, state_nxt;
   logic [TMO_W-1:0] tmo, tmo_nxt;
   logic [1:0]       pend     [NREG];
   logic [1:0]       pend_nxt [NREG];
   logic [CNT_W-1:0] stall_cnt;
   logic             err;

   logic raw, issue, commit, same_reg;
   logic pc_write, ifid_write, ifid_flush, idex_bubble;
   logic sb_err, tmo_err, stray_err;

   assign raw = hz.in_id_valid &
                ((hz.in_id_uses_rs & (pend[hz.in_id_rs] != 2'd0)) |
                 (hz.in_id_uses_rt & (pend[hz.in_id_rt] != 2'd0)));

   always_comb begin
      state_nxt   = state;
      tmo_nxt     = tmo;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      tmo_err     = 1'b0;
      stray_err   = 1'b0;
      case (state)
         ST_RUN: begin
            if (raw) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end else if (hz.in_id_valid && hz.in_id_ctrl_flow) begin
               state_nxt = ST_CTRL_WAIT;
               tmo_nxt   = '0;
            end
            stray_err = hz.in_wb_ctrl_flow & hz.in_wb_redirect;
         end
         ST_CTRL_WAIT: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            tmo_nxt     = TMO_W'(tmo + 1'b1);
            if (hz.in_wb_ctrl_flow) begin
               // A taken redirect loads the target and discards the held wrong-path fetch.
               pc_write   = hz.in_wb_redirect;
               ifid_flush = hz.in_wb_redirect;
               state_nxt  = ST_RUN;
            end else if (tmo == TMO_W'(CTRL_TIMEOUT - 1)) begin
               tmo_err   = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // Issue and commit to the same register cancel out, so neither side touches the counter.
   assign issue    = hz.in_id_valid & hz.in_id_ctrl_regwrt & ~idex_bubble;
   assign commit   = hz.in_wb_ctrl_regwrt;
   assign same_reg = issue & commit & (hz.in_id_rd == hz.in_wb_rd);

   always_comb begin
      pend_nxt = pend;
      sb_err   = 1'b0;
      if (issue && !same_reg) begin
         if (pend[hz.in_id_rd] == 2'd3) sb_err = 1'b1;
         else pend_nxt[hz.in_id_rd] = pend[hz.in_id_rd] + 2'd1;
      end
      if (commit && !same_reg) begin
         if (pend[hz.in_wb_rd] == 2'd0) sb_err = 1'b1;
         else pend_nxt[hz.in_wb_rd] = pend[hz.in_wb_rd] - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RUN;
         tmo       <= '0;
         stall_cnt <= '0;
         err       <= 1'b0;
         for (int i = 0; i < NREG; i++) pend[i] <= 2'd0;
      end else begin
         state <= state_nxt;
         tmo   <= tmo_nxt;
         pend  <= pend_nxt;
         err   <= err | sb_err | tmo_err | stray_err;
         if (idex_bubble && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign hz.out_pc_write    = pc_write;
   assign hz.out_ifid_write  = ifid_write;
   assign hz.out_ifid_flush  = ifid_flush;
   assign hz.out_idex_bubble = idex_bubble;
   assign hz.out_stall_count = stall_cnt;
   assign hz.out_err         = err;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle model checked on every falling edge,
// plus hand-computed expectations at key points of each scenario.
module tb_pipeline_hazard_ctrl;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipeline_hazard_ctrl #(.NREG(64), .CTRL_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- model: outstanding writes per register, branch age ----------------
   int m_pend [64];
   bit m_waiting;
   int m_wait_cycles;
   bit m_err;
   int m_stalls;

   always @(negedge clk) begin
      bit raw, e_bub, e_pc, e_ifw, e_fl, issue, commit;
      if (rst) begin
         foreach (m_pend[i]) m_pend[i] = 0;
         m_waiting = 0; m_wait_cycles = 0; m_err = 0; m_stalls = 0;
         chk("rst_pc_write", 32'(hz.out_pc_write), 1);
         chk("rst_ifid_write", 32'(hz.out_ifid_write), 1);
         chk("rst_ifid_flush", 32'(hz.out_ifid_flush), 0);
         chk("rst_idex_bubble", 32'(hz.out_idex_bubble), 0);
         chk("rst_stall_count", 32'(hz.out_stall_count), 0);
         chk("rst_err", 32'(hz.out_err), 0);
      end else begin
         raw = hz.in_id_valid &&
               ((hz.in_id_uses_rs && m_pend[hz.in_id_rs] > 0) ||
                (hz.in_id_uses_rt && m_pend[hz.in_id_rt] > 0));
         if (m_waiting) begin
            e_bub = 1; e_ifw = 0;
            e_fl  = hz.in_wb_ctrl_flow && hz.in_wb_redirect;
            e_pc  = e_fl;
         end else begin
            e_bub = raw; e_pc = !raw; e_ifw = !raw; e_fl = 0;
         end
         chk("pc_write", 32'(hz.out_pc_write), 32'(e_pc));
         chk("ifid_write", 32'(hz.out_ifid_write), 32'(e_ifw));
         chk("ifid_flush", 32'(hz.out_ifid_flush), 32'(e_fl));
         chk("idex_bubble", 32'(hz.out_idex_bubble), 32'(e_bub));
         chk("stall_count", 32'(hz.out_stall_count), 32'(m_stalls));
         chk("err", 32'(hz.out_err), 32'(m_err));

         issue  = hz.in_id_valid && hz.in_id_ctrl_regwrt && !e_bub;
         commit = hz.in_wb_ctrl_regwrt;
         if (!(issue && commit && hz.in_id_rd == hz.in_wb_rd)) begin
            if (issue) begin
               if (m_pend[hz.in_id_rd] == 3) m_err = 1;
               else m_pend[hz.in_id_rd]++;
            end
            if (commit) begin
               if (m_pend[hz.in_wb_rd] == 0) m_err = 1;
               else m_pend[hz.in_wb_rd]--;
            end
         end
         if (m_waiting) begin
            m_wait_cycles++;
            if (hz.in_wb_ctrl_flow) m_waiting = 0;
            else if (m_wait_cycles == TIMEOUT) begin m_err = 1; m_waiting = 0; end
         end else begin
            if (hz.in_wb_ctrl_flow && hz.in_wb_redirect) m_err = 1;
            if (!raw && hz.in_id_valid && hz.in_id_ctrl_flow) begin
               m_waiting = 1; m_wait_cycles = 0;
            end
         end
         if (e_bub && m_stalls < CNT_MAX) m_stalls++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                         input int rd, input bit wr, input bit flow);
      hz.in_id_valid       = v;
      hz.in_id_rs          = 6'(rs);
      hz.in_id_uses_rs     = urs;
      hz.in_id_rt          = 6'(rt);
      hz.in_id_uses_rt     = urt;
      hz.in_id_rd          = 6'(rd);
      hz.in_id_ctrl_regwrt = wr;
      hz.in_id_ctrl_flow   = flow;
   endtask

   task automatic set_wb(input bit wr, input int rd, input bit flow, input bit redir);
      hz.in_wb_ctrl_regwrt = wr;
      hz.in_wb_rd          = 6'(rd);
      hz.in_wb_ctrl_flow   = flow;
      hz.in_wb_redirect    = redir;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      idle();
      rst = 1'b1;
      repeat (2) cyc();
      #1;
      chk("t0_pc_write", 32'(hz.out_pc_write), 1);
      chk("t0_bubble", 32'(hz.out_idex_bubble), 0);
      rst = 1'b0;

      // 1: independent instructions flow freely
      for (int i = 0; i < 5; i++) begin
         set_id(1, 10 + i, 1, 0, 0, 0, 0, 0);
         #1;
         chk("t1_pc_write", 32'(hz.out_pc_write), 1);
         chk("t1_bubble", 32'(hz.out_idex_bubble), 0);
         cyc();
      end
      chk("t1_stall_count", 32'(hz.out_stall_count), 0);

      // 2: write r5 then read r5; commit two cycles after issue
      set_id(1, 0, 0, 0, 0, 5, 1, 0);
      cyc();
      set_id(1, 5, 1, 0, 0, 0, 0, 0);
      #1;
      chk("t2_bubble_a", 32'(hz.out_idex_bubble), 1);
      chk("t2_pc_hold_a", 32'(hz.out_pc_write), 0);
      cyc();
      set_wb(1, 5, 0, 0);
      #1;
      chk("t2_bubble_b", 32'(hz.out_idex_bubble), 1);
      chk("t2_pc_hold_b", 32'(hz.out_pc_write), 0);
      cyc();
      set_wb(0, 0, 0, 0);
      #1;
      chk("t2_released", 32'(hz.out_idex_bubble), 0);
      chk("t2_stall_count", 32'(hz.out_stall_count), 2);
      cyc();

      // 3: branch taken
      idle();
      set_id(1, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("t3_issue_pc", 32'(hz.out_pc_write), 1);
      cyc();
      set_id(1, 30, 1, 0, 0, 0, 0, 0);
      #1;
      chk("t3_wait_bubble", 32'(hz.out_idex_bubble), 1);
      chk("t3_wait_pc", 32'(hz.out_pc_write), 0);
      cyc();
      set_wb(0, 0, 1, 1);
      #1;
      chk("t3_flush", 32'(hz.out_ifid_flush), 1);
      chk("t3_res_pc", 32'(hz.out_pc_write), 1);
      chk("t3_res_bubble", 32'(hz.out_idex_bubble), 1);
      cyc();
      idle();
      #1;
      chk("t3_run_pc", 32'(hz.out_pc_write), 1);
      chk("t3_run_bubble", 32'(hz.out_idex_bubble), 0);
      chk("t3_stall_count", 32'(hz.out_stall_count), 4);
      cyc();

      // 4: branch not taken; held fall-through issues afterwards
      set_id(1, 0, 0, 0, 0, 0, 0, 1);
      cyc();
      set_id(1, 30, 1, 0, 0, 0, 0, 0);
      cyc();
      set_wb(0, 0, 1, 0);
      #1;
      chk("t4_no_flush", 32'(hz.out_ifid_flush), 0);
      chk("t4_res_pc", 32'(hz.out_pc_write), 0);
      cyc();
      set_wb(0, 0, 0, 0);
      #1;
      chk("t4_held_issues", 32'(hz.out_idex_bubble), 0);
      chk("t4_ifid_write", 32'(hz.out_ifid_write), 1);
      chk("t4_stall_count", 32'(hz.out_stall_count), 6);
      cyc();

      // 5: same-cycle issue+commit on r7, then underflow
      idle();
      set_id(1, 0, 0, 0, 0, 7, 1, 0);
      cyc();
      set_wb(1, 7, 0, 0);
      cyc();
      set_id(1, 0, 0, 7, 1, 0, 0, 0);
      #1;
      chk("t5_r7_still_pending", 32'(hz.out_idex_bubble), 1);
      cyc();
      set_wb(0, 0, 0, 0);
      #1;
      chk("t5_r7_cleared", 32'(hz.out_idex_bubble), 0);
      chk("t5_err_before", 32'(hz.out_err), 0);
      cyc();
      idle();
      set_wb(1, 9, 0, 0);
      cyc();
      idle();
      #1;
      chk("t5_underflow_err", 32'(hz.out_err), 1);
      cyc();

      // overflow: fourth outstanding write to r3
      do_reset();
      #1;
      chk("rs_err_clear", 32'(hz.out_err), 0);
      chk("rs_stall_clear", 32'(hz.out_stall_count), 0);
      for (int i = 0; i < 4; i++) begin
         set_id(1, 0, 0, 0, 0, 3, 1, 0);
         cyc();
         if (i == 2) chk("ov_err_at_3", 32'(hz.out_err), 0);
      end
      idle();
      #1;
      chk("ov_err", 32'(hz.out_err), 1);

      // stray redirect while nothing is in flight
      do_reset();
      set_wb(0, 0, 1, 1);
      #1;
      chk("stray_no_flush", 32'(hz.out_ifid_flush), 0);
      chk("stray_pc", 32'(hz.out_pc_write), 1);
      cyc();
      idle();
      #1;
      chk("stray_err", 32'(hz.out_err), 1);

      // 6: timeout, then reset in the middle of a control wait
      do_reset();
      set_id(1, 0, 0, 0, 0, 0, 0, 1);
      cyc();
      idle();
      for (int i = 0; i < TIMEOUT; i++) begin
         #1;
         chk("t6_wait_bubble", 32'(hz.out_idex_bubble), 1);
         cyc();
      end
      #1;
      chk("t6_timeout_err", 32'(hz.out_err), 1);
      chk("t6_back_to_run", 32'(hz.out_idex_bubble), 0);
      chk("t6_stall_count", 32'(hz.out_stall_count), 4);
      cyc();
      set_id(1, 0, 0, 0, 0, 0, 0, 1);
      cyc();
      idle();
      #1;
      chk("t6_in_wait", 32'(hz.out_idex_bubble), 1);
      rst = 1'b1;
      #1;
      chk("t6_async_pc", 32'(hz.out_pc_write), 1);
      chk("t6_async_bubble", 32'(hz.out_idex_bubble), 0);
      chk("t6_async_stall", 32'(hz.out_stall_count), 0);
      chk("t6_async_err", 32'(hz.out_err), 0);
      cyc();
      rst = 1'b0;
      #1;
      chk("t6_post_rst_pc", 32'(hz.out_pc_write), 1);
      cyc();
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
